sdram_port_arbiter: RTL and testbench
=====================================

Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller command port among three requesters: periodic refresh, the framebuffer line-fetch engine (640x480, one line per burst) and the CPU load/store path.
- Sits between the core/video blocks and the SDRAM controller.
- Holds off all traffic until SDRAM initialisation completes.
- Refresh never starves; video normally beats CPU.

Parameters:
- ADDR_W, 24, SDRAM word address width (32-bit words)
- VID_BURST, 160, words per video line burst (640 px x 8 bpp / 32)
- REF_BACKLOG, 7, maximum pending refresh count (saturating)
- CPU_GUARD, 2, max consecutive video grants while CPU waits (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- init_done  in  1  SDRAM init sequence finished, level
- refresh_tick  in  1  one-cycle pulse per refresh interval
- vid_req  in  1  video burst request, level, held until vid_done
- vid_addr  in  ADDR_W  burst start address
- vid_rvalid  out  1  video read word valid
- vid_rdata  out  32  video read word
- vid_done  out  1  one-cycle pulse, burst complete
- cpu_req  in  1  CPU access request, level, held until cpu_ack
- cpu_we  in  1  1 = write
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  32  write data
- cpu_wmask  in  4  byte enables
- cpu_ack  out  1  one-cycle pulse, access complete
- cpu_rdata  out  32  read data, valid with cpu_ack
- mem_valid  out  1  command valid to controller
- mem_ready  in  1  controller accepts command
- mem_cmd  out  2  0 = read, 1 = write, 2 = refresh
- mem_addr  out  ADDR_W  command address
- mem_len  out  8  burst length in words (1 for CPU, VID_BURST for video, 0 for refresh)
- mem_wdata  out  32  write data
- mem_wmask  out  4  byte enables
- mem_rvalid  in  1  read word valid
- mem_rdata  in  32  read word
- mem_done  in  1  one-cycle pulse, command finished

Behaviour:
- Reset (rst_n = 0 at posedge): state IDLE, refresh count 0, guard count 0; all outputs 0.
- State machine:
  - IDLE: arbitrates while init_done = 1. Priority order: refresh count > 0, then vid_req, then cpu_req.
  - Winner is registered. Next state is REF, VID or CPU, and mem_valid rises the next cycle (1-cycle grant latency).
  - REF, VID, CPU: mem_valid and the mem_* fields are held stable until a cycle with mem_valid & mem_ready. mem_valid drops the following cycle.
  - After the accept, the block waits for mem_done, then returns to IDLE.
  - IDLE spends at least one cycle between commands; there are no back-to-back grants.
- Refresh counter:
  - Increments on refresh_tick and saturates at REF_BACKLOG.
  - Decrements when a refresh command is accepted.
  - A tick and an accept in the same cycle leave the count unchanged.
  - Ticks are ignored while init_done = 0.
- Data routing:
  - In VID, mem_rvalid/mem_rdata pass to vid_rvalid/vid_rdata combinationally. vid_done = mem_done.
  - In CPU, cpu_rdata is registered on mem_rvalid. cpu_ack pulses the cycle after mem_done.
  - Outside these states, vid_rvalid = 0 and stray mem_rvalid is dropped.
- Requests dropped mid-transaction (vid_req or cpu_req falling after grant) do not abort. The command completes and the done/ack pulse is still issued.
- init_done falling mid-transaction: the current command completes, then the block stays in IDLE.
- Address and data are captured at grant. Requester changes after grant have no effect.

Optional Feature:
- Macro: SDRAM_ARB_CPU_GUARD_EN
- Defined:
  - A counter increments on each video grant made while cpu_req = 1, and clears on a CPU grant.
  - When the counter equals CPU_GUARD, CPU outranks video for the next grant. Refresh still outranks both.
- Undefined: strict priority, and the counter logic is absent.

Decomposition:
- Package sdram_arb_pkg holds:
  - state encoding (IDLE, REF, VID, CPU)
  - mem_cmd codes (CMD_RD, CMD_WR, CMD_REF)
  - default widths
- One sub-module: sdram_arb_refcnt, the saturating refresh backlog counter with tick/consume inputs.

Test Plan:
- init_done = 0, vid_req = cpu_req = 1, 5 refresh_ticks -> mem_valid stays 0 and refresh count stays 0. Raise init_done -> the first command is video with mem_len = 160.
- 9 refresh_ticks with no accept -> count saturates at 7. Then exactly 7 refresh commands (mem_cmd = 2) are issued before the pending video request is granted.
- CPU write, addr 0x000100, wdata 0xDEADBEEF, wmask 0x3, with mem_ready delayed 4 cycles -> mem_* stable across all 5 valid cycles. cpu_ack arrives exactly 1 cycle after mem_done.
- Video burst: the model returns 160 words -> 160 vid_rvalid pulses with matching data, one vid_done, and no cpu_ack during the burst.
- With SDRAM_ARB_CPU_GUARD_EN and vid_req, cpu_req held high -> grant order is VID, VID, CPU, VID, VID, CPU. Without the macro, the CPU is never granted.
- Reset asserted mid video burst -> all outputs 0 the next cycle and refresh count 0. After reset, arbitration restarts from IDLE.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// ---------------------------------------------------------------------------
// sdram_arb_pkg
// Shared constants for the SDRAM command-port arbiter:
//   - FSM state encoding (IDLE, REF, VID, CPU)
//   - controller command codes placed on mem_cmd
//   - default parameter values for widths, burst length, backlog and guard
//   - cnt_w(): counter width able to hold 0..max_val
// ---------------------------------------------------------------------------
package sdram_arb_pkg;

   localparam int ADDR_W_DEF      = 24;
   localparam int VID_BURST_DEF   = 160;  // 640 px x 8 bpp / 32-bit words
   localparam int REF_BACKLOG_DEF = 7;
   localparam int CPU_GUARD_DEF   = 2;

   // FSM states
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REF  = 2'd1;
   localparam logic [1:0] ST_VID  = 2'd2;
   localparam logic [1:0] ST_CPU  = 2'd3;

   // mem_cmd codes understood by the SDRAM controller
   localparam logic [1:0] CMD_RD  = 2'd0;
   localparam logic [1:0] CMD_WR  = 2'd1;
   localparam logic [1:0] CMD_REF = 2'd2;

   // Width of a counter that must represent every value 0..max_val.
   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/sdram_arb_refcnt.sv
// ---------------------------------------------------------------------------
// sdram_arb_refcnt
// Saturating count of refresh commands owed to the SDRAM.
//   clk        system clock
//   rst_n      synchronous active-low reset
//   tick_i     one refresh interval elapsed (already qualified by the caller)
//   consume_i  a refresh command was accepted by the controller
//   count_o    pending refresh count, 0..REF_BACKLOG
// A tick and a consume in the same cycle cancel out.
// ---------------------------------------------------------------------------
module sdram_arb_refcnt
   import sdram_arb_pkg::*;
#(
   parameter  int REF_BACKLOG = REF_BACKLOG_DEF,
   localparam int CNT_W       = cnt_w(REF_BACKLOG)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             tick_i,
   input  logic             consume_i,
   output logic [CNT_W-1:0] count_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REF_BACKLOG);

   logic [CNT_W-1:0] count_q, count_d;

   // NOTE: every variable assigned in always_comb gets a default first;
   // a path that leaves it unassigned would infer a latch.
   always_comb begin
      count_d = count_q;
      if (tick_i && !consume_i && (count_q != CNT_MAX)) begin
         count_d = count_q + CNT_W'(1);
      end else if (consume_i && !tick_i && (count_q != '0)) begin
         count_d = count_q - CNT_W'(1);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of its inputs, independent of block order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

// File: rtl/sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// sdram_port_arbiter
// Shares the single SDRAM controller command port between periodic refresh,
// the framebuffer line-fetch engine and the CPU load/store path.
// Priority: pending refresh > video > CPU. Nothing is granted until
// init_done is high. One command is outstanding at a time, and at least one
// IDLE cycle separates consecutive commands.
//
// Ports
//   clk, rst_n                  clock, synchronous active-low reset
//   init_done                   SDRAM initialisation finished (level)
//   refresh_tick                one pulse per refresh interval
//   vid_req / vid_addr          video line burst request and start address
//   vid_rvalid / vid_rdata      video read words (combinational pass-through)
//   vid_done                    burst complete pulse
//   cpu_req/_we/_addr/_wdata/_wmask   CPU single-word access
//   cpu_ack / cpu_rdata         access complete pulse, read data
//   mem_valid/_ready/_cmd/_addr/_len/_wdata/_wmask   command to controller
//   mem_rvalid / mem_rdata / mem_done                 controller responses
//
// Build option
//   SDRAM_ARB_CPU_GUARD_EN  when defined, after CPU_GUARD consecutive video
//                           grants made while the CPU was waiting, the CPU
//                           outranks video for the next grant.
// ---------------------------------------------------------------------------
module sdram_port_arbiter
   import sdram_arb_pkg::*;
#(
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int VID_BURST   = VID_BURST_DEF,
   parameter int REF_BACKLOG = REF_BACKLOG_DEF
`ifdef SDRAM_ARB_CPU_GUARD_EN
  ,parameter int CPU_GUARD   = CPU_GUARD_DEF
`endif
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              init_done,
   input  logic              refresh_tick,
   input  logic              vid_req,
   input  logic [ADDR_W-1:0] vid_addr,
   output logic              vid_rvalid,
   output logic [31:0]       vid_rdata,
   output logic              vid_done,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [31:0]       cpu_wdata,
   input  logic [3:0]        cpu_wmask,
   output logic              cpu_ack,
   output logic [31:0]       cpu_rdata,
   output logic              mem_valid,
   input  logic              mem_ready,
   output logic [1:0]        mem_cmd,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_len,
   output logic [31:0]       mem_wdata,
   output logic [3:0]        mem_wmask,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   input  logic              mem_done
);

   localparam int REF_W = cnt_w(REF_BACKLOG);

   logic [1:0]        state_q,     state_d;
   logic              mem_valid_q, mem_valid_d;
   logic [1:0]        mem_cmd_q,   mem_cmd_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic [7:0]        mem_len_q,   mem_len_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic [3:0]        mem_wmask_q, mem_wmask_d;
   logic              cpu_ack_q,   cpu_ack_d;
   logic [31:0]       cpu_rdata_q, cpu_rdata_d;

   logic [REF_W-1:0]  ref_cnt;
   logic              accept;
   logic              cmd_done;
   logic              cpu_first;
   logic [1:0]        grant;

   assign accept   = mem_valid_q && mem_ready;
   // mem_done only counts once the command has been accepted.
   assign cmd_done = (state_q != ST_IDLE) && !mem_valid_q && mem_done;

   // Ticks before init_done are not owed: the init sequence refreshes itself.
   sdram_arb_refcnt #(
      .REF_BACKLOG (REF_BACKLOG)
   ) u_refcnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick_i    (refresh_tick && init_done),
      .consume_i ((state_q == ST_REF) && accept),
      .count_o   (ref_cnt)
   );

`ifdef SDRAM_ARB_CPU_GUARD_EN
   localparam int GRD_W = cnt_w(CPU_GUARD);
   localparam logic [GRD_W-1:0] GRD_MAX = GRD_W'(CPU_GUARD);

   logic [GRD_W-1:0] guard_q, guard_d;

   assign cpu_first = cpu_req && (guard_q == GRD_MAX);

   always_comb begin
      guard_d = guard_q;
      if (grant == ST_CPU) begin
         guard_d = '0;
      end else if ((grant == ST_VID) && cpu_req && (guard_q != GRD_MAX)) begin
         guard_d = guard_q + GRD_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         guard_q <= '0;
      end else begin
         guard_q <= guard_d;
      end
   end
`else
   assign cpu_first = 1'b0;
`endif

   // Arbitration result for this cycle; ST_IDLE means nothing granted.
   always_comb begin
      grant = ST_IDLE;
      if ((state_q == ST_IDLE) && init_done) begin
         if (ref_cnt != '0) begin
            grant = ST_REF;
         end else if (cpu_first) begin
            grant = ST_CPU;
         end else if (vid_req) begin
            grant = ST_VID;
         end else if (cpu_req) begin
            grant = ST_CPU;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      mem_valid_d = mem_valid_q;
      mem_cmd_d   = mem_cmd_q;
      mem_addr_d  = mem_addr_q;
      mem_len_d   = mem_len_q;
      mem_wdata_d = mem_wdata_q;
      mem_wmask_d = mem_wmask_q;
      cpu_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;

      if (state_q == ST_IDLE) begin
         // Command fields are captured here, so requester changes after the
         // grant cannot disturb the command the controller sees.
         if (grant != ST_IDLE) begin
            state_d     = grant;
            mem_valid_d = 1'b1;
         end
         case (grant)
            ST_REF: begin
               mem_cmd_d   = CMD_REF;
               mem_addr_d  = '0;
               mem_len_d   = 8'd0;
               mem_wdata_d = '0;
               mem_wmask_d = '0;
            end
            ST_VID: begin
               mem_cmd_d   = CMD_RD;
               mem_addr_d  = vid_addr;
               mem_len_d   = 8'(VID_BURST);
               mem_wdata_d = '0;
               mem_wmask_d = '0;
            end
            ST_CPU: begin
               mem_cmd_d   = cpu_we ? CMD_WR : CMD_RD;
               mem_addr_d  = cpu_addr;
               mem_len_d   = 8'd1;
               mem_wdata_d = cpu_wdata;
               mem_wmask_d = cpu_wmask;
            end
            default: ;
         endcase
      end else begin
         if (accept) begin
            mem_valid_d = 1'b0;
         end
         if (cmd_done) begin
            state_d = ST_IDLE;
         end
         if (state_q == ST_CPU) begin
            if (mem_rvalid) begin
               cpu_rdata_d = mem_rdata;
            end
            cpu_ack_d = cmd_done;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         mem_valid_q <= 1'b0;
         mem_cmd_q   <= '0;
         mem_addr_q  <= '0;
         mem_len_q   <= '0;
         mem_wdata_q <= '0;
         mem_wmask_q <= '0;
         cpu_ack_q   <= 1'b0;
         cpu_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_valid_q <= mem_valid_d;
         mem_cmd_q   <= mem_cmd_d;
         mem_addr_q  <= mem_addr_d;
         mem_len_q   <= mem_len_d;
         mem_wdata_q <= mem_wdata_d;
         mem_wmask_q <= mem_wmask_d;
         cpu_ack_q   <= cpu_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
      end
   end

   // Video read data is a pure pass-through while a video burst owns the
   // port; stray read words in any other state are dropped.
   assign vid_rvalid = (state_q == ST_VID) && mem_rvalid;
   assign vid_rdata  = (state_q == ST_VID) ? mem_rdata : 32'd0;
   assign vid_done   = (state_q == ST_VID) && cmd_done;

   assign cpu_ack    = cpu_ack_q;
   assign cpu_rdata  = cpu_rdata_q;

   assign mem_valid  = mem_valid_q;
   assign mem_cmd    = mem_cmd_q;
   assign mem_addr   = mem_addr_q;
   assign mem_len    = mem_len_q;
   assign mem_wdata  = mem_wdata_q;
   assign mem_wmask  = mem_wmask_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sdram_port_arbiter
// Directed bench for sdram_port_arbiter. The bench plays the SDRAM
// controller: it accepts commands after a chosen delay, returns read words
// {8'hA5, addr + i} and pulses mem_done. Inputs are driven and outputs
// sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_sdram_port_arbiter;

   localparam int ADDR_W = 24;

   logic              clk;
   logic              rst_n;
   logic              init_done;
   logic              refresh_tick;
   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic              vid_rvalid;
   logic [31:0]       vid_rdata;
   logic              vid_done;
   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [31:0]       cpu_wdata;
   logic [3:0]        cpu_wmask;
   logic              cpu_ack;
   logic [31:0]       cpu_rdata;
   logic              mem_valid;
   logic              mem_ready;
   logic [1:0]        mem_cmd;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_len;
   logic [31:0]       mem_wdata;
   logic [3:0]        mem_wmask;
   logic              mem_rvalid;
   logic [31:0]       mem_rdata;
   logic              mem_done;

   sdram_port_arbiter dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .init_done    (init_done),
      .refresh_tick (refresh_tick),
      .vid_req      (vid_req),
      .vid_addr     (vid_addr),
      .vid_rvalid   (vid_rvalid),
      .vid_rdata    (vid_rdata),
      .vid_done     (vid_done),
      .cpu_req      (cpu_req),
      .cpu_we       (cpu_we),
      .cpu_addr     (cpu_addr),
      .cpu_wdata    (cpu_wdata),
      .cpu_wmask    (cpu_wmask),
      .cpu_ack      (cpu_ack),
      .cpu_rdata    (cpu_rdata),
      .mem_valid    (mem_valid),
      .mem_ready    (mem_ready),
      .mem_cmd      (mem_cmd),
      .mem_addr     (mem_addr),
      .mem_len      (mem_len),
      .mem_wdata    (mem_wdata),
      .mem_wmask    (mem_wmask),
      .mem_rvalid   (mem_rvalid),
      .mem_rdata    (mem_rdata),
      .mem_done     (mem_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pat(input logic [ADDR_W-1:0] a, input int i);
      return {8'hA5, a + 24'(i)};
   endfunction

   // Results of the most recent served command.
   logic [1:0]        last_cmd;
   logic [ADDR_W-1:0] last_addr;
   logic [7:0]        last_len;
   logic [31:0]       last_wdata;
   logic [3:0]        last_wmask;
   int                valid_cycles, stable_err, vid_ok, vid_done_cnt, ack_during;
   logic              ack_at_done, ack_after;
   int                ticks_to_send = 0;
   logic              poke_cpu = 1'b0;

   // Controller model: wait for a command, hold mem_ready low for rdy_dly
   // cycles, accept, return read words if it is a read, then pulse mem_done.
   task automatic serve(input int rdy_dly);
      int waited = 0;
      valid_cycles = 0; stable_err = 0; vid_ok = 0; vid_done_cnt = 0;
      ack_during = 0; ack_at_done = 1'b0; ack_after = 1'b0;
      while (mem_valid !== 1'b1 && waited < 400) begin
         @(negedge clk);
         waited++;
      end
      if (mem_valid !== 1'b1) begin
         check("grant_timeout", 64'(mem_valid), 64'd1);
         last_cmd = 2'b11;
         return;
      end
      last_cmd   = mem_cmd;
      last_addr  = mem_addr;
      last_len   = mem_len;
      last_wdata = mem_wdata;
      last_wmask = mem_wmask;
      valid_cycles = 1;
      if (poke_cpu) begin
         cpu_addr  = 24'hFFFFFF;
         cpu_wdata = 32'h0;
      end
      for (int i = 0; i < rdy_dly; i++) begin
         @(negedge clk);
         if (mem_valid === 1'b1) valid_cycles++;
         if (mem_cmd !== last_cmd || mem_addr !== last_addr || mem_len !== last_len ||
             mem_wdata !== last_wdata || mem_wmask !== last_wmask) stable_err++;
      end
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      if (mem_valid !== 1'b0) stable_err++;
      if (last_cmd == 2'd0) begin
         for (int i = 0; i < int'(last_len); i++) begin
            mem_rvalid   = 1'b1;
            mem_rdata    = pat(last_addr, i);
            refresh_tick = (i < 2 * ticks_to_send) && (i % 2 == 0);
            #1;
            if (vid_rvalid === 1'b1 && vid_rdata === pat(last_addr, i)) vid_ok++;
            if (cpu_ack === 1'b1) ack_during++;
            @(negedge clk);
         end
      end
      refresh_tick  = 1'b0;
      mem_rvalid    = 1'b0;
      mem_rdata     = 32'h0;
      ticks_to_send = 0;
      mem_done = 1'b1;
      #1;
      if (vid_done === 1'b1) vid_done_cnt++;
      ack_at_done = cpu_ack;
      @(negedge clk);
      mem_done = 1'b0;
      #1;
      if (vid_done === 1'b1) vid_done_cnt++;
      ack_after = cpu_ack;
   endtask

   initial begin
      int valid_hi;
      int n_ref;
      int ref_len_bad;
      int waited;
      logic [7:0] exp_len;

      rst_n = 1'b0; init_done = 1'b0; refresh_tick = 1'b0;
      vid_req = 1'b0; vid_addr = 24'h001000;
      cpu_req = 1'b0; cpu_we = 1'b1; cpu_addr = 24'h000100;
      cpu_wdata = 32'hDEADBEEF; cpu_wmask = 4'h3;
      mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0; mem_done = 1'b0;
      repeat (2) @(negedge clk);

      // Reset state
      check("rst_mem_valid", 64'(mem_valid), 64'd0);
      check("rst_cpu_ack",   64'(cpu_ack),   64'd0);
      check("rst_mem_len",   64'(mem_len),   64'd0);
      check("rst_refcnt",    64'(dut.ref_cnt), 64'd0);

      // Everything held off while init_done is low; ticks ignored.
      rst_n = 1'b1; vid_req = 1'b1; cpu_req = 1'b1;
      valid_hi = 0;
      for (int i = 0; i < 10; i++) begin
         refresh_tick = (i % 2 == 0);
         @(negedge clk);
         if (mem_valid !== 1'b0) valid_hi++;
      end
      refresh_tick = 1'b0;
      check("preinit_valid_cycles", 64'(valid_hi), 64'd0);
      check("preinit_refcnt", 64'(dut.ref_cnt), 64'd0);

      // First command after init: video, one-cycle grant latency.
      init_done = 1'b1;
      @(negedge clk);
      check("grant_latency", 64'(mem_valid), 64'd1);
      ticks_to_send = 9;
      serve(0);
      check("vid1_cmd",        64'(last_cmd), 64'd0);
      check("vid1_len",        64'(last_len), 64'd160);
      check("vid1_addr",       64'(last_addr), 64'h001000);
      check("vid1_words",      64'(vid_ok), 64'd160);
      check("vid1_done_count", 64'(vid_done_cnt), 64'd1);
      check("vid1_no_cpu_ack", 64'(ack_during), 64'd0);
      check("vid1_protocol",   64'(stable_err), 64'd0);
      check("refcnt_saturated", 64'(dut.ref_cnt), 64'd7);

      // Seven refreshes drain the backlog before video is served again.
      n_ref = 0; ref_len_bad = 0;
      serve(0);
      while (last_cmd == 2'd2 && n_ref < 10) begin
         if (last_len != 8'd0) ref_len_bad++;
         n_ref++;
         serve(0);
      end
      vid_req = 1'b0;
      check("ref_count_issued", 64'(n_ref), 64'd7);
      check("ref_len_zero",     64'(ref_len_bad), 64'd0);
      check("post_ref_cmd",     64'(last_cmd), 64'd0);
      check("post_ref_len",     64'(last_len), 64'd160);
      check("refcnt_drained",   64'(dut.ref_cnt), 64'd0);

      // CPU write with 4-cycle ready stall; requester changes after grant.
      poke_cpu = 1'b1;
      serve(4);
      poke_cpu = 1'b0;
      check("cpuw_cmd",     64'(last_cmd), 64'd1);
      check("cpuw_addr",    64'(last_addr), 64'h000100);
      check("cpuw_wdata",   64'(last_wdata), 64'hDEADBEEF);
      check("cpuw_wmask",   64'(last_wmask), 64'h3);
      check("cpuw_len",     64'(last_len), 64'd1);
      check("cpuw_valid_cycles", 64'(valid_cycles), 64'd5);
      check("cpuw_stable",  64'(stable_err), 64'd0);
      check("cpuw_ack_at_done", 64'(ack_at_done), 64'd0);
      check("cpuw_ack_after",   64'(ack_after), 64'd1);

      // CPU read
      cpu_we = 1'b0; cpu_addr = 24'h000200;
      serve(1);
      check("cpur_cmd",   64'(last_cmd), 64'd0);
      check("cpur_len",   64'(last_len), 64'd1);
      check("cpur_addr",  64'(last_addr), 64'h000200);
      check("cpur_ack",   64'(ack_after), 64'd1);
      check("cpur_rdata", 64'(cpu_rdata), 64'hA5000200);

      // Video and CPU both requesting: grant order depends on the guard.
      cpu_addr = 24'h000300; vid_req = 1'b1;
      for (int g = 0; g < 6; g++) begin
         serve(0);
`ifdef SDRAM_ARB_CPU_GUARD_EN
         exp_len = (g % 3 == 2) ? 8'd1 : 8'd160;
`else
         exp_len = 8'd160;
`endif
         check($sformatf("guard_grant%0d_len", g), 64'(last_len), 64'(exp_len));
      end

      // Reset in the middle of a video burst.
      cpu_req = 1'b0;
      waited = 0;
      while (mem_valid !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      check("mid_vid_grant", 64'(mem_valid), 64'd1);
      mem_ready = 1'b1;
      @(negedge clk);
      mem_ready = 1'b0;
      mem_rvalid = 1'b1; mem_rdata = 32'h11112222; refresh_tick = 1'b1;
      #1;
      check("mid_vid_passthru", 64'(vid_rdata), 64'h11112222);
      @(negedge clk);
      refresh_tick = 1'b0;
      check("refcnt_before_reset", 64'(dut.ref_cnt), 64'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("rst2_mem_valid", 64'(mem_valid), 64'd0);
      check("rst2_mem_len",   64'(mem_len), 64'd0);
      check("rst2_mem_addr",  64'(mem_addr), 64'd0);
      check("rst2_vid_rvalid", 64'(vid_rvalid), 64'd0);
      check("rst2_vid_rdata", 64'(vid_rdata), 64'd0);
      check("rst2_cpu_rdata", 64'(cpu_rdata), 64'd0);
      check("rst2_refcnt",    64'(dut.ref_cnt), 64'd0);
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      rst_n = 1'b1;
      @(negedge clk);
      check("restart_grant", 64'(mem_valid), 64'd1);
      serve(0);
      check("restart_len",  64'(last_len), 64'd160);
      check("restart_done", 64'(vid_done_cnt), 64'd1);
      vid_req = 1'b0;
      repeat (2) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
